rx_frame_parser: RTL and testbench
==================================

RX_FRAME_PARSER -- requirements
Module: rx_frame_parser

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, byte width; fixed at 8 for this protocol.
REQ-002 SHALL have parameter MAX_LEN, default 16, maximum payload bytes per frame.
REQ-003 SHALL have parameter TIMEOUT_CYC, default 130000, idle clk cycles between accepted bytes before a frame is aborted.
REQ-004 SHALL have parameter SOF, default 8'hA5, start-of-frame byte.
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-007 SHALL have port valid_in  input  1  upstream byte valid.
REQ-008 SHALL have port ready_in  output  1  parser accepts byte this cycle.
REQ-009 SHALL have port data_in  input  DATA_WIDTH  upstream byte.
REQ-010 SHALL have port payload_valid  output  1  payload byte valid.
REQ-011 SHALL have port payload_ready  input  1  downstream accepts payload byte.
REQ-012 SHALL have port payload_data  output  DATA_WIDTH  payload byte.
REQ-013 SHALL have port payload_last  output  1  marks final payload byte of frame.
REQ-014 SHALL have port frame_ok  output  1  one-cycle pulse, frame checksum good.
REQ-015 SHALL have port frame_err  output  1  one-cycle pulse, frame discarded.
REQ-016 SHALL have port err_code  output  2  last error: 00 none, 01 bad length, 10 bad checksum, 11 timeout.

Function
REQ-017 SHALL parse frames: SOF, LEN, LEN payload bytes, CSUM; CSUM = XOR of LEN and all payload bytes.
REQ-018 SHALL implement states HUNT, LEN, DATA, CSUM, SEND; reset state HUNT.
REQ-019 SHALL define accept = valid_in & ready_in; ready_in = 1 in HUNT/LEN/DATA/CSUM, 0 in SEND.
REQ-020 HUNT: accepted SOF -> LEN; any other accepted byte discarded silently, no error.
REQ-021 LEN: accepted byte 1..MAX_LEN -> DATA, store length, init checksum to that byte; 0 or >MAX_LEN -> frame_err, err_code=01, HUNT.
REQ-022 DATA: each accepted byte written to frame buffer and XORed into checksum; after LEN-th byte -> CSUM.
REQ-023 CSUM: accepted byte equal to running checksum -> SEND, frame_ok pulse next cycle; mismatch -> frame_err pulse next cycle, err_code=10, buffer discarded, HUNT.
REQ-024 SEND: payload_valid asserted from cycle after CSUM accept; bytes presented in arrival order; payload_last high only with final byte; after final transfer -> HUNT next cycle.
REQ-025 payload_data and payload_last SHALL stay stable while payload_valid & !payload_ready.
REQ-026 Timeout counter SHALL clear on every accept and in HUNT/SEND; reaching TIMEOUT_CYC in LEN/DATA/CSUM -> frame_err, err_code=11, HUNT.
REQ-027 SOF bytes inside LEN/DATA/CSUM SHALL be treated as ordinary data (no resync).
REQ-028 err_code SHALL update only with a frame_err pulse and hold otherwise; frame_ok does not clear it.
REQ-029 frame_ok and frame_err SHALL never assert in the same cycle.

Reset
REQ-030 On rst: state HUNT, ready_in=0 while rst high, payload_valid=0, payload_data=0, payload_last=0, frame_ok=0, frame_err=0, err_code=00, counters and pointers 0.
REQ-031 rst asserted mid-frame or mid-SEND SHALL drop the frame with no pulses emitted.

Structure
REQ-032 Shared package uart_pkg SHALL hold state encoding, err_code constants, default SOF.
REQ-033 Payload storage SHALL be sub-module rx_frame_buf: MAX_LEN x DATA_WIDTH, write pointer, read pointer, clear input.

Verification
REQ-034 Bytes A5 03 11 22 33 03 -> payload 11,22,33, last on 33, one frame_ok, err_code 00.
REQ-035 Bytes A5 03 11 22 33 04 -> frame_err, err_code=10, payload_valid never high.
REQ-036 Bytes 00 FF A5 01 7E 7F -> leading bytes ignored, payload 7E with last, frame_ok.
REQ-037 Bytes A5 11 -> frame_err, err_code=01; following A5 01 55 54 parses ok.
REQ-038 Valid frame with payload_ready low 5 cycles in SEND -> data held stable, ready_in=0 throughout, no byte lost.
REQ-039 A5 02 AA then no valid_in for TIMEOUT_CYC cycles -> frame_err, err_code=11; rst mid-SEND -> all outputs 0 next cycle.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the byte-stream frame parser: state encoding, error codes, default SOF.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_HUNT,
        ST_LEN,
        ST_DATA,
        ST_CSUM,
        ST_SEND
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_LEN     = 2'b01;
    localparam logic [1:0] ERR_CSUM    = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT = 2'b11;

    localparam logic [7:0] SOF_DEFAULT = 8'hA5;

endpackage

// File: rtl/rx_frame_buf.sv
// Payload store for one frame: linear write, linear read, bulk clear of both pointers.
// Latency: write visible next cycle; read data is combinational from the read pointer.
// Backpressure: none; the parser only writes in DATA and only advances reads on a downstream accept.
module rx_frame_buf #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 8,
    parameter int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_adv,
    output logic [WIDTH-1:0] rd_data,
    output logic [PW-1:0]    wr_ptr,
    output logic [PW-1:0]    rd_ptr
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en)
                wr_ptr <= wr_ptr + PW'(1);
            if (rd_adv)
                rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Storage needs no reset: pointers alone define what is valid.
    always_ff @(posedge clk) begin
        if (wr_en)
            mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];

endmodule

// File: rtl/rx_frame_parser.sv
// Parses SOF/LEN/payload/CSUM byte frames, releasing the payload only after the checksum verifies.
// Latency: frame_ok/frame_err one cycle after the deciding byte; first payload byte the same cycle as frame_ok.
// Backpressure: ready_in drops for the whole SEND phase; payload is held stable while payload_ready is low.
module rx_frame_parser
    import uart_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 8,
    parameter int                    MAX_LEN     = 16,
    parameter int                    TIMEOUT_CYC = 130000,
    parameter logic [DATA_WIDTH-1:0] SOF         = SOF_DEFAULT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    output logic                  ready_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  payload_valid,
    input  logic                  payload_ready,
    output logic [DATA_WIDTH-1:0] payload_data,
    output logic                  payload_last,
    output logic                  frame_ok,
    output logic                  frame_err,
    output logic [1:0]            err_code
);

    localparam int                    PW        = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int                    TW        = $clog2(TIMEOUT_CYC + 1);
    localparam logic [DATA_WIDTH-1:0] MAX_LEN_W = DATA_WIDTH'(MAX_LEN);
    localparam logic [TW-1:0]         TMO_LAST  = TW'(TIMEOUT_CYC - 1);

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] len_q, len_d;
    logic [DATA_WIDTH-1:0] csum_q, csum_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic                  ok_q, ok_d;
    logic                  err_q, err_d;
    logic [1:0]            code_q, code_d;

    logic                  buf_clr, buf_wr, buf_rd;
    logic [DATA_WIDTH-1:0] rd_data;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic                  accept, is_last;

    rx_frame_buf #(
        .DEPTH (MAX_LEN),
        .WIDTH (DATA_WIDTH),
        .PW    (PW)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .clr     (buf_clr),
        .wr_en   (buf_wr),
        .wr_data (data_in),
        .rd_adv  (buf_rd),
        .rd_data (rd_data),
        .wr_ptr  (wr_ptr),
        .rd_ptr  (rd_ptr)
    );

    assign ready_in      = !rst && (state_q != ST_SEND);
    assign accept        = valid_in && ready_in;
    assign is_last       = (DATA_WIDTH'(rd_ptr) == len_q - DATA_WIDTH'(1));
    assign payload_valid = (state_q == ST_SEND);
    assign payload_data  = payload_valid ? rd_data : '0;
    assign payload_last  = payload_valid && is_last;
    assign frame_ok      = ok_q;
    assign frame_err     = err_q;
    assign err_code      = code_q;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        csum_d  = csum_q;
        tmo_d   = '0;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        buf_clr = 1'b0;
        buf_wr  = 1'b0;
        buf_rd  = 1'b0;

        case (state_q)
            ST_HUNT: begin
                buf_clr = 1'b1;
                if (accept && data_in == SOF)
                    state_d = ST_LEN;
            end
            ST_LEN: begin
                if (accept) begin
                    if (data_in == '0 || data_in > MAX_LEN_W) begin
                        err_d   = 1'b1;
                        code_d  = ERR_LEN;
                        state_d = ST_HUNT;
                    end else begin
                        len_d   = data_in;
                        csum_d  = data_in;
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    buf_wr = 1'b1;
                    csum_d = csum_q ^ data_in;
                    if (DATA_WIDTH'(wr_ptr) == len_q - DATA_WIDTH'(1))
                        state_d = ST_CSUM;
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    if (data_in == csum_q) begin
                        ok_d    = 1'b1;
                        state_d = ST_SEND;
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ERR_CSUM;
                        state_d = ST_HUNT;
                    end
                end
            end
            ST_SEND: begin
                if (payload_ready) begin
                    buf_rd = 1'b1;
                    if (is_last)
                        state_d = ST_HUNT;
                end
            end
            default: state_d = ST_HUNT;
        endcase

        // Idle time only counts while a frame is partially received.
        if ((state_q inside {ST_LEN, ST_DATA, ST_CSUM}) && !accept) begin
            if (tmo_q == TMO_LAST) begin
                err_d   = 1'b1;
                code_d  = ERR_TIMEOUT;
                state_d = ST_HUNT;
            end else begin
                tmo_d = tmo_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_HUNT;
            len_q   <= '0;
            csum_q  <= '0;
            tmo_q   <= '0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            csum_q  <= csum_d;
            tmo_q   <= tmo_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

endmodule

// File: tb/tb_rx_frame_parser.sv
// Scoreboard bench for rx_frame_parser: byte-stream reference model feeds an expectation queue, a monitor checks DUT outputs.
module tb_rx_frame_parser;

    localparam int MAX_LEN = 16;
    localparam int TMO     = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_in = 1'b0;
    logic [7:0] data_in = 8'h00;
    logic       payload_ready = 1'b0;
    logic       ready_in, payload_valid, payload_last, frame_ok, frame_err;
    logic [7:0] payload_data;
    logic [1:0] err_code;

    always #5 clk = ~clk;

    rx_frame_parser #(
        .DATA_WIDTH  (8),
        .MAX_LEN     (MAX_LEN),
        .TIMEOUT_CYC (TMO),
        .SOF         (8'hA5)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .valid_in      (valid_in),
        .ready_in      (ready_in),
        .data_in       (data_in),
        .payload_valid (payload_valid),
        .payload_ready (payload_ready),
        .payload_data  (payload_data),
        .payload_last  (payload_last),
        .frame_ok      (frame_ok),
        .frame_err     (frame_err),
        .err_code      (err_code)
    );

    // kind: 0 payload byte, 1 frame_ok, 2 frame_err
    typedef struct {
        int         kind;
        logic [7:0] data;
        logic       last;
        logic [1:0] code;
    } ev_t;

    ev_t        exp_q[$];
    ev_t        mon_e;
    logic [7:0] sq[$];
    int         n_checks = 0;
    int         n_fail = 0;
    int         rdy_mode = 2;
    int         cyc = 0;
    int         acc_cyc = 0;
    int         err_cyc = 0;
    logic [1:0] last_code = 2'b00;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;
    logic       prev_last = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name, input int act, input int req);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got %0d, required %0d", name, act, req);
    endtask

    function automatic void push_ev(input int k, input logic [7:0] d, input logic l, input logic [1:0] c);
        ev_t e;
        e.kind = k;
        e.data = d;
        e.last = l;
        e.code = c;
        exp_q.push_back(e);
    endfunction

    // Reference: scan the complete byte list for frames and derive the expected events.
    function automatic void model_seq();
        int         i = 0;
        int         n = sq.size();
        int         len;
        logic [7:0] cs;
        while (i < n) begin
            if (sq[i] != 8'hA5) begin
                i++;
                continue;
            end
            if (i + 1 >= n) break;
            len = int'(sq[i+1]);
            if (len == 0 || len > MAX_LEN) begin
                push_ev(2, 8'h00, 1'b0, 2'b01);
                i += 2;
                continue;
            end
            if (i + 2 + len >= n) break;
            cs = sq[i+1];
            for (int j = 0; j < len; j++) cs ^= sq[i+2+j];
            if (sq[i+2+len] == cs) begin
                push_ev(1, 8'h00, 1'b0, 2'b00);
                for (int j = 0; j < len; j++) push_ev(0, sq[i+2+j], j == len - 1, 2'b00);
            end else begin
                push_ev(2, 8'h00, 1'b0, 2'b10);
            end
            i += len + 3;
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        if (rdy_mode == 0)      payload_ready = 1'b0;
        else if (rdy_mode == 1) payload_ready = 1'b1;
        else                    payload_ready = ($urandom_range(0, 3) != 0);
    end

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", payload_valid, 1);
                chk("stall_data", payload_data, prev_data);
                chk("stall_last", payload_last, prev_last);
            end
            if (payload_valid) chk("ready_in_in_send", ready_in, 0);
            chk("ok_err_exclusive", frame_ok & frame_err, 0);
            if (frame_ok || frame_err) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_pulse", {frame_ok, frame_err}, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("event_kind", frame_ok ? 1 : 2, mon_e.kind);
                    if (frame_err) begin
                        err_cyc = cyc;
                        chk("err_code", err_code, mon_e.code);
                        last_code = mon_e.code;
                    end else begin
                        chk("err_code_hold", err_code, last_code);
                    end
                end
            end
            if (payload_valid && payload_ready) begin
                if (exp_q.size() == 0) begin
                    fail_now("unexpected_payload", payload_data, 0);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("payload_kind", 0, mon_e.kind);
                    chk("payload_data", payload_data, mon_e.data);
                    chk("payload_last", payload_last, mon_e.last);
                end
            end
            prev_stall = payload_valid && !payload_ready;
            prev_data  = payload_data;
            prev_last  = payload_last;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bit done = 1'b0;
        valid_in = 1'b1;
        data_in  = b;
        while (!done) begin
            @(negedge clk);
            if (ready_in) begin
                @(posedge clk);
                #1;
                acc_cyc  = cyc;
                valid_in = 1'b0;
                done     = 1'b1;
            end else begin
                n++;
                if (n > 500) begin
                    fail_now("accept_wait", n, 500);
                    valid_in = 1'b0;
                    done     = 1'b1;
                end
            end
        end
    endtask

    task automatic run_seq(input int max_gap);
        model_seq();
        foreach (sq[i]) begin
            send_byte(sq[i]);
            repeat ($urandom_range(0, max_gap)) begin
                @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic drain(input int bound);
        int n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) fail_now("drain", exp_q.size(), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_payload_valid();
        int n = 0;
        while (!payload_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!payload_valid) fail_now("payload_valid_wait", n, 200);
    endtask

    int         t, len;
    logic [7:0] b, cs;

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready_in", ready_in, 0);
        chk("rst_payload_valid", payload_valid, 0);
        chk("rst_payload_data", payload_data, 0);
        chk("rst_payload_last", payload_last, 0);
        chk("rst_frame_ok", frame_ok, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_err_code", err_code, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        sq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        run_seq(0);
        drain(100);
        sq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h04};
        run_seq(1);
        drain(100);
        sq = '{8'h00, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7F};
        run_seq(1);
        drain(100);
        sq = '{8'hA5, 8'h11, 8'hA5, 8'h01, 8'h55, 8'h54};
        run_seq(0);
        drain(100);

        // Downstream stalls the first SEND cycles; the monitor checks hold and ready_in.
        rdy_mode = 0;
        sq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
        run_seq(0);
        wait_payload_valid();
        repeat (6) @(posedge clk);
        #1;
        rdy_mode = 1;
        drain(100);
        rdy_mode = 2;

        repeat (40) begin
            sq.delete();
            repeat ($urandom_range(0, 2)) begin
                do b = 8'($urandom_range(0, 255)); while (b == 8'hA5);
                sq.push_back(b);
            end
            t = $urandom_range(0, 9);
            sq.push_back(8'hA5);
            if (t < 2) begin
                sq.push_back($urandom_range(0, 1) ? 8'h00 : 8'($urandom_range(MAX_LEN + 1, 255)));
            end else begin
                len = $urandom_range(1, MAX_LEN);
                cs  = 8'(len);
                sq.push_back(cs);
                for (int j = 0; j < len; j++) begin
                    b = 8'($urandom_range(0, 255));
                    sq.push_back(b);
                    cs ^= b;
                end
                if (t < 4) cs ^= 8'($urandom_range(1, 255));
                sq.push_back(cs);
            end
            run_seq(3);
        end
        drain(400);

        // Partial frame then silence.
        push_ev(2, 8'h00, 1'b0, 2'b11);
        send_byte(8'hA5);
        send_byte(8'h02);
        send_byte(8'hAA);
        t = acc_cyc;
        drain(TMO + 20);
        chk("timeout_latency", err_cyc - t, TMO);
        sq = '{8'hA5, 8'h01, 8'h55, 8'h54};
        run_seq(0);
        drain(100);

        // Reset while a frame is being delivered.
        rdy_mode = 0;
        sq = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h32};
        run_seq(0);
        wait_payload_valid();
        @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        last_code = 2'b00;
        @(negedge clk);
        chk("midrst_ready_in", ready_in, 0);
        chk("midrst_payload_valid", payload_valid, 0);
        chk("midrst_payload_data", payload_data, 0);
        chk("midrst_payload_last", payload_last, 0);
        chk("midrst_frame_ok", frame_ok, 0);
        chk("midrst_frame_err", frame_err, 0);
        chk("midrst_err_code", err_code, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        rdy_mode = 2;
        sq = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
        run_seq(1);
        drain(100);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
